fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage: drives the icache/memory read port, prefetches into an
//  in-order instruction buffer, and delivers {pc,instr} to decode (IF->ID) under stall.
//  Handles branch redirect from EX with flush and discard of stale in-flight responses.
//  Sits between the icache and the decode stage in the core pipeline.
// PARAMETERS
//  XLEN       16       instruction/data word width (bits)
//  AW         16       fetch address width (bits); PC increments by 1 word per instruction
//  BUF_DEPTH  4        instruction buffer entries (power of 2, >=2)
//  MAX_OUTST  4        max outstanding memory reads (<=BUF_DEPTH)
//  RESET_PC   'h0000   PC after reset
// PORTS
//  clk                 in   1     clock, rising edge
//  reset               in   1     asynchronous, active-low reset (asserted at 0)
//  stall               in   1     decode cannot accept this cycle
//  ex_if_branch_en     in   1     redirect request from EX
//  ex_if_branch_target in   AW    redirect PC
//  mem_r_en            out  1     read request valid
//  mem_r_addr          out  AW    read address
//  mem_r_gnt           in   1     request accepted this cycle (mem_r_en & mem_r_gnt = issue)
//  mem_r_valid         in   1     response valid (in order, >=1 cycle after issue)
//  mem_r_data          in   XLEN  response instruction
//  if_id_valid         out  1     if_id_pc/instr hold a valid instruction
//  if_id_pc            out  AW    PC of delivered instruction
//  if_id_instr         out  XLEN  delivered instruction
// BEHAVIOUR
//  Reset (reset=0): fetch_pc=RESET_PC, buffer empty, outst=0, discard=0, state=S_BOOT;
//   mem_r_en=0, mem_r_addr=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_instr=0. Mid-op reset drops all.
//  FSM: S_BOOT -(1 cycle)-> S_FETCH; S_FETCH -(branch_en)-> S_REDIR; S_REDIR -(1 cycle)-> S_FETCH.
//  Issue: in S_FETCH, mem_r_en=1 when outst + buf_count < BUF_DEPTH and outst < MAX_OUTST;
//   mem_r_addr=fetch_pc; on issue fetch_pc<=fetch_pc+1 (wraps mod 2^AW), outst++.
//   mem_r_en/addr held stable until gnt (no withdraw), except on redirect.
//  Response: mem_r_valid decrements outst; if discard>0 the word is dropped and discard--,
//   else {resp_pc,mem_r_data} pushed to buffer, resp_pc<=resp_pc+1. Space is reserved at
//   issue, so the buffer never overflows; overflow is an assertion error.
//  Delivery: IF->ID register loads from buffer head when !stall and buffer non-empty
//   (if_id_valid<=1); !stall and empty -> if_id_valid<=0; stall -> IF->ID holds. Latency
//   issue->if_id_valid >= resp latency + 1 cycle; sustained 1 instr/cycle with 1-cycle memory.
//  Redirect (branch_en=1, any state, priority over all): buffer flushed, IF->ID valid<=0,
//   discard<=outst - (mem_r_valid?1:0) + (issue this cycle?1:0), fetch_pc<=resp_pc<=
//   branch_target, mem_r_en=0 that cycle (S_REDIR); fetch resumes next cycle. Response in the
//   redirect cycle is dropped. Redirect under stall still flushes. Back-to-back redirects: last wins.
//  Simultaneous push+pop on full buffer legal; pop on empty ignored.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_flush_cnt (32b, +1 per redirect) and
//   perf_starve_cnt (32b, +1 per cycle !stall & buffer empty & !branch_en); both reset to 0,
//   saturate at all-ones. Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  core_pkg: XLEN, AW, RESET_PC defaults; fetch state enum {S_BOOT,S_FETCH,S_REDIR};
//   fetch_entry_t = {pc[AW], instr[XLEN]}.
//  Sub-module fetch_buffer: sync FIFO of fetch_entry_t, DEPTH=BUF_DEPTH, push/pop/flush,
//   count, full/empty; same clk/reset. PC/outstanding/discard logic and FSM stay in fetch_unit.
// TESTING
//  1-cycle memory, gnt=1, no stall, RESET_PC=0 -> if_id_pc 0,1,2,3... one per cycle, instr match.
//  stall=1 for 10 cycles -> IF->ID holds; mem_r_en drops once outst+count=4; no instr lost/duped.
//  3-cycle memory, 3 reads outstanding, branch_en target 'h0100 -> 3 stale words dropped,
//   next if_id_pc='h0100, if_id_valid=0 during redirect cycle.
//  fetch_pc='hFFFF -> next issued mem_r_addr='h0000 (wrap).
//  gnt low for 5 cycles -> mem_r_addr stable, no duplicate issue; reset=0 mid-fetch -> all outputs
//   to reset values, restart at RESET_PC.
//  FETCH_PERF_EN: 2 redirects, 7 starved cycles -> perf_flush_cnt=2, perf_starve_cnt=7.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Macro: FETCH_PERF_EN (consumed by fetch_unit) adds the perf counter ports.
// Contents:
//   CORE_XLEN / CORE_AW / CORE_RESET_PC : default word width, address width, boot PC
//   fetch_state_t                       : fetch control states
//   fetch_entry_t                       : {pc, instr} pair held in the instruction buffer
package fetch_unit_pkg;

  localparam int CORE_XLEN = 16;
  localparam int CORE_AW   = 16;
  localparam logic [CORE_AW-1:0] CORE_RESET_PC = '0;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_REDIR = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [CORE_AW-1:0]   pc;
    logic [CORE_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read port between the fetch stage (master) and the icache (slave).
// Signals:
//   mem_r_en    master->slave  read request valid, held until granted
//   mem_r_addr  master->slave  read word address
//   mem_r_gnt   slave->master  request accepted this cycle
//   mem_r_valid slave->master  in-order response valid
//   mem_r_data  slave->master  response instruction word
interface fetch_unit_if #(
  parameter int AW   = 16,
  parameter int XLEN = 16
);
  logic            mem_r_en;
  logic [AW-1:0]   mem_r_addr;
  logic            mem_r_gnt;
  logic            mem_r_valid;
  logic [XLEN-1:0] mem_r_data;

  modport master (
    output mem_r_en, mem_r_addr,
    input  mem_r_gnt, mem_r_valid, mem_r_data
  );

  modport slave (
    input  mem_r_en, mem_r_addr,
    output mem_r_gnt, mem_r_valid, mem_r_data
  );
endinterface

// File: rtl/fetch_unit_buffer.sv
// fetch_buffer: synchronous FIFO holding fetched {pc, instr} entries in program order.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i, data_i    write an entry (accepted when not full, or when popping the same cycle)
//   pop_i             drop the head entry (ignored when empty)
//   flush_i           discard all entries; wins over push/pop
//   data_o            head entry
//   count_o           number of stored entries
//   full_o, empty_o   occupancy flags
module fetch_buffer #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [W-1:0]               data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PW'(1);
      if (do_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Issues sequential reads to the icache, keeps responses
// in an in-order buffer and hands {pc, instr} to decode through the IF->ID register.
// A branch redirect from EX flushes everything and drops responses still in flight.
// Macro: FETCH_PERF_EN adds perf_flush_cnt / perf_starve_cnt outputs.
// Ports:
//   clk, reset                clock, asynchronous active-low reset
//   stall                     decode cannot accept this cycle
//   ex_if_branch_en/_target   redirect request and new PC
//   mem                       icache read port (fetch_unit_if.master)
//   if_id_valid/_pc/_instr    IF->ID pipeline register
//   perf_flush_cnt            (FETCH_PERF_EN) redirects seen, saturating
//   perf_starve_cnt           (FETCH_PERF_EN) cycles decode was ready but buffer empty, saturating
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int            XLEN      = CORE_XLEN,
  parameter int            AW        = CORE_AW,
  parameter int            BUF_DEPTH = 4,
  parameter int            MAX_OUTST = 4,
  parameter logic [AW-1:0] RESET_PC  = CORE_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            ex_if_branch_en,
  input  logic [AW-1:0]   ex_if_branch_target,
  fetch_unit_if.master    mem,
  output logic            if_id_valid,
  output logic [AW-1:0]   if_id_pc,
  output logic [XLEN-1:0] if_id_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_flush_cnt,
  output logic [31:0]     perf_starve_cnt
`endif
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int EW = AW + XLEN;

  fetch_state_t  state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d, discard_q, discard_d, buf_count;
  logic [CW:0]   inflight;
  logic          buf_full, buf_empty, push, pop, issue, redirect, resp;
  logic [EW-1:0] buf_head;

  assign redirect = ex_if_branch_en;
  assign resp     = mem.mem_r_valid;

  // Buffer space is reserved at issue: requests in flight plus stored entries never exceed
  // the buffer depth, so every response has a slot. The sum only shrinks while a request
  // waits for grant, so mem_r_en cannot drop without a redirect.
  assign inflight       = {1'b0, outst_q} + {1'b0, buf_count};
  assign mem.mem_r_en   = (state_q == S_FETCH) && !redirect &&
                          (inflight < (CW+1)'(BUF_DEPTH)) && (outst_q < CW'(MAX_OUTST));
  assign mem.mem_r_addr = fetch_pc_q;
  assign issue          = mem.mem_r_en && mem.mem_r_gnt;
  assign pop            = !stall && !buf_empty && !redirect;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    discard_d  = discard_q;
    push       = 1'b0;

    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: state_d = S_FETCH;
      S_REDIR: state_d = S_FETCH;
      default: state_d = S_BOOT;
    endcase

    if (redirect) begin
      // No issue can happen this cycle (mem_r_en is gated), so everything still
      // outstanding after this cycle's response is stale and must be dropped.
      state_d    = S_REDIR;
      fetch_pc_d = ex_if_branch_target;
      resp_pc_d  = ex_if_branch_target;
      outst_d    = outst_q - CW'(resp);
      discard_d  = outst_q - CW'(resp);
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + AW'(1);
      outst_d = outst_q + CW'(issue) - CW'(resp);
      if (resp) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CW'(1);
        end else begin
          push      = 1'b1;
          resp_pc_d = resp_pc_q + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
    end
  end

  fetch_buffer #(.W(EW), .DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .data_i  ({resp_pc_q, mem.mem_r_data}),
    .pop_i   (pop),
    .flush_i (redirect),
    .data_o  (buf_head),
    .count_o (buf_count),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

  // IF->ID register: a redirect kills the slot, a stall freezes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= '0;
    end else if (redirect) begin
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if_id_valid <= !buf_empty;
      if (!buf_empty) {if_id_pc, if_id_instr} <= buf_head;
    end
  end

  assert property (@(posedge clk) disable iff (!reset) !(push && buf_full && !pop));
  assert property (@(posedge clk) disable iff (!reset) !(resp && outst_q == '0));

`ifdef FETCH_PERF_EN
  logic [31:0] flush_cnt_q, starve_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      if (redirect) flush_cnt_q <= sat_inc(flush_cnt_q);
      if (!stall && buf_empty && !redirect) starve_cnt_q <= sat_inc(starve_cnt_q);
    end
  end

  assign perf_flush_cnt  = flush_cnt_q;
  assign perf_starve_cnt = starve_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int AW = 16;
  localparam int XLEN = 16;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_en = 1'b0;
  logic [15:0] br_tgt = 16'h0000;
  logic        if_v;
  logic [15:0] if_pc, if_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] pf, ps;
`endif

  fetch_unit_if #(.AW(AW), .XLEN(XLEN)) mif();

  fetch_unit #(.XLEN(XLEN), .AW(AW), .BUF_DEPTH(4), .MAX_OUTST(4), .RESET_PC(RST_PC)) dut (
    .clk                 (clk),
    .reset               (reset),
    .stall               (stall),
    .ex_if_branch_en     (br_en),
    .ex_if_branch_target (br_tgt),
    .mem                 (mif),
    .if_id_valid         (if_v),
    .if_id_pc            (if_pc),
    .if_id_instr         (if_instr)
`ifdef FETCH_PERF_EN
    ,
    .perf_flush_cnt      (pf),
    .perf_starve_cnt     (ps)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  int          cyc = 0;
  int          lat = 1;
  int          issued = 0;
  int          delivered = 0;
  logic [15:0] q_addr[$];
  int          q_due[$];
  logic [15:0] exp_fpc, exp_pc;
  logic        prev_stall = 1'b0, prev_branch = 1'b0, prev_en = 1'b0, prev_gnt = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic        last_v = 1'b0;
  logic [15:0] last_pc = 16'h0, last_instr = 16'h0;
  logic        redir_pending = 1'b0;
  logic [15:0] first_after;

  function automatic logic [15:0] memword(input logic [15:0] a);
    return (a * 16'd40503) ^ 16'h5A3C;
  endfunction

  // Memory responder plus scoreboard, evaluated mid-cycle when everything is stable.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!reset) begin
      q_addr.delete();
      q_due.delete();
      mif.mem_r_valid = 1'b0;
      mif.mem_r_data  = 16'h0;
      exp_fpc = RST_PC;
      exp_pc  = RST_PC;
      prev_stall = 1'b0; prev_branch = 1'b0; prev_en = 1'b0; prev_gnt = 1'b0;
      prev_addr = 16'h0;
      last_v = 1'b0; last_pc = 16'h0; last_instr = 16'h0;
      issued = 0; delivered = 0;
      redir_pending = 1'b0;
    end else begin
      // IF->ID reflects the last clock edge
      if (prev_branch) begin
        total++;
        if (if_v !== 1'b0) begin
          bad++; $display("FAIL redirect_bubble: if_id_valid=%b required 0", if_v);
        end
        redir_pending = 1'b1;
      end else if (!prev_stall) begin
        if (if_v === 1'b1) begin
          total++;
          if (if_pc !== exp_pc || if_instr !== memword(exp_pc)) begin
            bad++;
            $display("FAIL deliver: pc=%h instr=%h required pc=%h instr=%h",
                     if_pc, if_instr, exp_pc, memword(exp_pc));
          end
          if (redir_pending) begin
            first_after = if_pc;
            redir_pending = 1'b0;
          end
          exp_pc = exp_pc + 16'd1;
          delivered++;
        end
      end else begin
        total++;
        if ({if_v, if_pc, if_instr} !== {last_v, last_pc, last_instr}) begin
          bad++;
          $display("FAIL stall_hold: v=%b pc=%h instr=%h required v=%b pc=%h instr=%h",
                   if_v, if_pc, if_instr, last_v, last_pc, last_instr);
        end
      end

      // Read request side
      if (br_en) begin
        total++;
        if (mif.mem_r_en !== 1'b0) begin
          bad++; $display("FAIL redirect_no_req: mem_r_en=%b required 0", mif.mem_r_en);
        end
      end else if (prev_en && !prev_gnt && !prev_branch) begin
        total++;
        if (mif.mem_r_en !== 1'b1 || mif.mem_r_addr !== prev_addr) begin
          bad++;
          $display("FAIL req_hold: en=%b addr=%h required en=1 addr=%h",
                   mif.mem_r_en, mif.mem_r_addr, prev_addr);
        end
      end
      if (mif.mem_r_en === 1'b1) begin
        total++;
        if (mif.mem_r_addr !== exp_fpc) begin
          bad++; $display("FAIL issue_addr: addr=%h required %h", mif.mem_r_addr, exp_fpc);
        end
      end
      if (mif.mem_r_en === 1'b1 && mif.mem_r_gnt === 1'b1) begin
        q_addr.push_back(mif.mem_r_addr);
        q_due.push_back(cyc + lat);
        exp_fpc = exp_fpc + 16'd1;
        issued++;
      end
      if (br_en) begin
        exp_fpc = br_tgt;
        exp_pc  = br_tgt;
      end

      // Response for the upcoming edge
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        mif.mem_r_valid = 1'b1;
        mif.mem_r_data  = memword(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        mif.mem_r_valid = 1'b0;
        mif.mem_r_data  = 16'($urandom);
      end

      prev_stall  = stall;
      prev_branch = br_en;
      prev_en     = mif.mem_r_en;
      prev_gnt    = mif.mem_r_gnt;
      prev_addr   = mif.mem_r_addr;
      last_v      = if_v;
      last_pc     = if_pc;
      last_instr  = if_instr;
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    stall = 1'b0; br_en = 1'b0; br_tgt = 16'h0; mif.mem_r_gnt = 1'b1;
    #2 reset = 1'b0;
    cycles(3);
    total++; if (mif.mem_r_en !== 1'b0) begin bad++; $display("FAIL rst_en: got %b required 0", mif.mem_r_en); end
    total++; if (mif.mem_r_addr !== RST_PC) begin bad++; $display("FAIL rst_addr: got %h required %h", mif.mem_r_addr, RST_PC); end
    total++; if (if_v !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b required 0", if_v); end
    total++; if (if_pc !== 16'h0) begin bad++; $display("FAIL rst_pc: got %h required 0", if_pc); end
    total++; if (if_instr !== 16'h0) begin bad++; $display("FAIL rst_instr: got %h required 0", if_instr); end
    reset = 1'b1;
    #1;
    total++; if (mif.mem_r_en !== 1'b0) begin bad++; $display("FAIL boot_no_req: en=%b required 0", mif.mem_r_en); end
    cycles(1);
    total++;
    if (mif.mem_r_en !== 1'b1 || mif.mem_r_addr !== RST_PC) begin
      bad++; $display("FAIL first_req: en=%b addr=%h required en=1 addr=%h", mif.mem_r_en, mif.mem_r_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    int d0;
    lat = 1; stall = 1'b0; mif.mem_r_gnt = 1'b1;
    cycles(6);
    d0 = delivered;
    cycles(16);
    total++;
    if (delivered - d0 != 16) begin
      bad++; $display("FAIL stream_rate: got %0d instrs in 16 cycles required 16", delivered - d0);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    cycles(10);
    total++;
    if (mif.mem_r_en !== 1'b0) begin bad++; $display("FAIL stall_req_stop: en=%b required 0", mif.mem_r_en); end
    total++;
    if (issued - delivered != 4) begin
      bad++; $display("FAIL stall_inflight: held=%0d required 4", issued - delivered);
    end
    total++;
    if (if_v !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b required 1", if_v); end
    stall = 1'b0;
    cycles(8);
  endtask

  task automatic test_gnt_hold();
    logic [15:0] a0;
    int iss0;
    cycles(4);
    mif.mem_r_gnt = 1'b0;
    a0 = mif.mem_r_addr;
    iss0 = issued;
    cycles(5);
    total++;
    if (mif.mem_r_en !== 1'b1 || mif.mem_r_addr !== a0 || issued != iss0) begin
      bad++;
      $display("FAIL gnt_hold: en=%b addr=%h issues=%0d required en=1 addr=%h issues=%0d",
               mif.mem_r_en, mif.mem_r_addr, issued, a0, iss0);
    end
    mif.mem_r_gnt = 1'b1;
    cycles(6);
  endtask

  task automatic test_redirect();
    lat = 3;
    cycles(10);
    first_after = 'x;
    br_en = 1'b1; br_tgt = 16'h0100;
    cycles(1);
    br_en = 1'b0;
    total++;
    if (if_v !== 1'b0 || mif.mem_r_en !== 1'b0) begin
      bad++; $display("FAIL redir_cycle: valid=%b en=%b required 0 0", if_v, mif.mem_r_en);
    end
    cycles(14);
    total++;
    if (first_after !== 16'h0100) begin
      bad++; $display("FAIL redir_target: first pc=%h required 0100", first_after);
    end
    lat = 1;
    cycles(6);
  endtask

  task automatic test_wrap();
    lat = 1;
    cycles(4);
    br_en = 1'b1; br_tgt = 16'hFFFF;
    cycles(1);
    br_en = 1'b0;
    cycles(1);
    total++;
    if (mif.mem_r_en !== 1'b1 || mif.mem_r_addr !== 16'hFFFF) begin
      bad++; $display("FAIL wrap_pre: en=%b addr=%h required 1 ffff", mif.mem_r_en, mif.mem_r_addr);
    end
    cycles(1);
    total++;
    if (mif.mem_r_en !== 1'b1 || mif.mem_r_addr !== 16'h0000) begin
      bad++; $display("FAIL wrap_addr: en=%b addr=%h required 1 0000", mif.mem_r_en, mif.mem_r_addr);
    end
    cycles(10);
  endtask

  task automatic test_midreset();
    cycles(3);
    reset = 1'b0;
    #1;
    total++;
    if (mif.mem_r_en !== 1'b0 || mif.mem_r_addr !== RST_PC || if_v !== 1'b0 ||
        if_pc !== 16'h0 || if_instr !== 16'h0) begin
      bad++;
      $display("FAIL midreset_outputs: en=%b addr=%h v=%b pc=%h instr=%h required 0 %h 0 0 0",
               mif.mem_r_en, mif.mem_r_addr, if_v, if_pc, if_instr, RST_PC);
    end
    cycles(2);
    reset = 1'b1;
    cycles(10);
    total++;
    if (delivered < 5) begin
      bad++; $display("FAIL midreset_restart: delivered=%0d required >=5", delivered);
    end
  endtask

  task automatic test_random();
    int d0;
    d0 = delivered;
    for (int ph = 0; ph < 4; ph++) begin
      lat = 1 + ph;
      for (int i = 0; i < 150; i++) begin
        stall = ($urandom_range(0, 3) == 0);
        mif.mem_r_gnt = ($urandom_range(0, 9) < 7);
        br_en = ($urandom_range(0, 24) == 0);
        br_tgt = 16'($urandom);
        cycles(1);
      end
    end
    stall = 1'b0; br_en = 1'b0; mif.mem_r_gnt = 1'b1; lat = 1;
    cycles(20);
    total++;
    if (delivered - d0 < 100) begin
      bad++; $display("FAIL random_progress: delivered=%0d required >=100", delivered - d0);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    stall = 1'b1; br_en = 1'b0; mif.mem_r_gnt = 1'b0;
    reset = 1'b0;
    cycles(2);
    reset = 1'b1;
    cycles(2);
    total++;
    if (pf !== 32'd0 || ps !== 32'd0) begin
      bad++; $display("FAIL perf_reset: flush=%0d starve=%0d required 0 0", pf, ps);
    end
    stall = 1'b0;
    cycles(3);
    br_en = 1'b1; cycles(1);
    br_en = 1'b0; cycles(2);
    br_en = 1'b1; cycles(1);
    br_en = 1'b0; cycles(2);
    stall = 1'b1;
    cycles(1);
    total++;
    if (pf !== 32'd2 || ps !== 32'd7) begin
      bad++; $display("FAIL perf_counts: flush=%0d starve=%0d required 2 7", pf, ps);
    end
    stall = 1'b0; mif.mem_r_gnt = 1'b1;
    cycles(4);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200us");
    $fatal(1);
  end

  initial begin
    mif.mem_r_gnt   = 1'b1;
    mif.mem_r_valid = 1'b0;
    mif.mem_r_data  = 16'h0;
    test_reset();
    test_stream();
    test_stall();
    test_gnt_hold();
    test_redirect();
    test_wrap();
    test_midreset();
    test_random();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
